// File: rtl/if_id_stage_hs_pkg.sv
// Shared IF/ID pipeline definitions.
// Holds the NOP encoding, the occupancy states and the fetch payload layout.
package if_id_stage_hs_pkg;

    // RISC-V "addi x0, x0, 0"
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_stage_hs_skid_buffer.sv
// Generic ready/valid register with an optional second entry.
// With the second entry present, in_ready is a flop and full throughput is kept.
module if_id_stage_hs_skid_buffer
    import if_id_stage_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 96,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    occ_state_e            state_reg;
    occ_state_e            state_next;
    logic [DATA_WIDTH-1:0] main_reg;
    logic [DATA_WIDTH-1:0] skid_reg;
    logic                  accept;
    logic                  consume;

    assign accept    = in_valid && in_ready && !clear;
    assign consume   = out_valid && out_ready;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (accept) state_next = FULL;
                FULL: begin
                    if (accept && !consume)
                        state_next = SKID;
                    else if (!accept && consume)
                        state_next = EMPTY;
                end
                SKID:    if (consume) state_next = FULL;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == SKID) begin
                if (consume && !clear)
                    main_reg <= skid_reg;
            end else if (accept) begin
                // A word arriving while main is stuck parks behind it.
                if (state_reg == FULL && !consume)
                    skid_reg <= in_data;
                else
                    main_reg <= in_data;
            end
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic ready_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    ready_reg <= 1'b1;
                else
                    ready_reg <= (state_next != SKID);
            end
            assign in_ready = ready_reg;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

endmodule

// File: rtl/if_id_stage_hs.sv
// IF/ID pipeline register with valid/ready handshake, flush-to-NOP
// and a saturating count of cycles decode held the stage back.
module if_id_stage_hs
    import if_id_stage_hs_pkg::*;
#(
    parameter int                     PC_WIDTH    = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEFAULT),
    parameter bit                     SKID_EN     = 1'b1,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [CNT_WIDTH-1:0]   stall_cnt,
    input  logic                   clr_cnt
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } payload_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    payload_t             in_payload;
    payload_t             held_payload;
    logic                 held_valid;
    logic [CNT_WIDTH-1:0] stall_cnt_reg;

    assign in_payload = '{pc: in_pc, instr: in_instr};

    if_id_stage_hs_skid_buffer #(
        .DATA_WIDTH ($bits(payload_t)),
        .SKID_EN    (SKID_EN)
    ) u_skid_buffer (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (held_valid),
        .out_ready (out_ready),
        .out_data  (held_payload)
    );

    // Decode never sees stale data: an empty stage shows a zero PC and a NOP.
    assign out_valid = held_valid;
    assign out_pc    = held_valid ? held_payload.pc    : '0;
    assign out_instr = held_valid ? held_payload.instr : NOP_INSTR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_reg <= '0;
        else if (clr_cnt)
            stall_cnt_reg <= '0;
        else if (held_valid && !out_ready && !flush && stall_cnt_reg != CNT_MAX)
            stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_if_id_stage_hs.sv
// Bench for if_id_stage_hs: skid and no-skid variants against a queue-level model.
module tb_if_id_stage_hs;
    import if_id_stage_hs_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, flush, out_ready, clr_cnt;
    logic [63:0] in_pc;
    logic [31:0] in_instr;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [63:0] out_pc_a, out_pc_b;
    logic [31:0] out_instr_a, out_instr_b;
    logic [CNT_W-1:0] stall_cnt_a, stall_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_payload_t q [2][$];
    int             cnt [2];

    always #5 clk = ~clk;

    if_id_stage_hs #(.SKID_EN(1'b1), .CNT_WIDTH(CNT_W)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_pc(out_pc_a), .out_instr(out_instr_a),
        .stall_cnt(stall_cnt_a), .clr_cnt(clr_cnt));

    if_id_stage_hs #(.SKID_EN(1'b0), .CNT_WIDTH(CNT_W)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_pc(out_pc_b), .out_instr(out_instr_b),
        .stall_cnt(stall_cnt_b), .clr_cnt(clr_cnt));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Skid variant holds up to two words; the plain variant takes a word only when it can empty.
    function automatic bit model_ready(int d, int sz, logic ordy);
        if (d == 0) return sz < 2;
        return (sz == 0) || ordy;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                cnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int  sz;
                bit  rdy;
                if_id_payload_t e;
                sz  = q[d].size();
                rdy = model_ready(d, sz, out_ready);
                if (clr_cnt)
                    cnt[d] = 0;
                else if (sz > 0 && !out_ready && !flush && cnt[d] < CNT_MAX)
                    cnt[d]++;
                if (flush) begin
                    q[d].delete();
                end else begin
                    if (sz > 0 && out_ready) begin
                        e = q[d].pop_front();
                        $display("dut%0d out pc=%h instr=%h", d, e.pc, e.instr);
                    end
                    if (in_valid && rdy)
                        q[d].push_back('{pc: in_pc, instr: in_instr});
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int          sz;
            logic [63:0] e_pc;
            logic [31:0] e_in;
            sz   = q[d].size();
            e_pc = (sz > 0) ? q[d][0].pc : 64'd0;
            e_in = (sz > 0) ? q[d][0].instr : NOP;
            if (d == 0) begin
                chk("a.out_valid", 64'(out_valid_a), 64'(sz > 0));
                chk("a.out_pc",    out_pc_a, e_pc);
                chk("a.out_instr", 64'(out_instr_a), 64'(e_in));
                chk("a.in_ready",  64'(in_ready_a), 64'(model_ready(0, sz, out_ready)));
                chk("a.stall_cnt", 64'(stall_cnt_a), 64'(cnt[0]));
            end else begin
                chk("b.out_valid", 64'(out_valid_b), 64'(sz > 0));
                chk("b.out_pc",    out_pc_b, e_pc);
                chk("b.out_instr", 64'(out_instr_b), 64'(e_in));
                chk("b.in_ready",  64'(in_ready_b), 64'(model_ready(1, sz, out_ready)));
                chk("b.stall_cnt", 64'(stall_cnt_b), 64'(cnt[1]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [63:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = 32'h0000_0000 | pc[31:0] | 32'h0000_0003;
    endtask

    initial begin
        in_valid = 0; flush = 0; out_ready = 0; clr_cnt = 0;
        in_pc = '0; in_instr = '0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // reset values, while held and just after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.held.out_valid", 64'(out_valid_a), 64'd0);
        chk("rst.held.in_ready",  64'(in_ready_a), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", 64'(out_valid_a), 64'd0);
        chk("rst.out_instr", 64'(out_instr_a), 64'h13);
        chk("rst.out_pc",    out_pc_a, 64'd0);
        chk("rst.in_ready",  64'(in_ready_a), 64'd1);
        chk("rst.stall_cnt", 64'(stall_cnt_a), 64'd0);

        // streaming, no bubbles
        step();
        out_ready = 1'b1;
        present(64'h1000);
        step();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) present(64'h1004 + 64'(4 * i));
            else in_valid = 1'b0;
            @(negedge clk);
            chk("stream.a.out_pc", out_pc_a, 64'h1000 + 64'(4 * i));
            chk("stream.b.out_pc", out_pc_b, 64'h1000 + 64'(4 * i));
            chk("stream.a.out_valid", 64'(out_valid_a), 64'd1);
            step();
        end

        // backpressure into the skid entry
        present(64'h1000);
        step();
        out_ready = 1'b0;
        present(64'h1004);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.a.in_ready", 64'(in_ready_a), 64'd0);
        chk("bp.a.out_pc",   out_pc_a, 64'h1000);
        step();
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.a.stall_cnt", 64'(stall_cnt_a), 64'd3);
        chk("bp.b.stall_cnt", 64'(stall_cnt_b), 64'd3);
        chk("bp.a.first",     out_pc_a, 64'h1000);
        step();
        @(negedge clk);
        chk("bp.a.second",     out_pc_a, 64'h1004);
        chk("bp.b.out_valid",  64'(out_valid_b), 64'd0);
        step();
        @(negedge clk);
        chk("bp.a.drained",    64'(out_valid_a), 64'd0);

        // flush while in the skid state
        out_ready = 1'b0;
        present(64'h1100);
        step();
        present(64'h1104);
        step();
        @(negedge clk);
        chk("fl.a.skid_ready", 64'(in_ready_a), 64'd0);
        flush = 1'b1;
        present(64'h2000);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl.a.out_valid", 64'(out_valid_a), 64'd0);
        chk("fl.a.out_instr", 64'(out_instr_a), 64'h13);
        chk("fl.a.out_pc",    out_pc_a, 64'd0);
        chk("fl.a.in_ready",  64'(in_ready_a), 64'd1);
        chk("fl.a.stall_cnt", 64'(stall_cnt_a), 64'd4);
        out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("fl.a.no_2000", 64'(out_valid_a), 64'd0);

        // saturation and clear
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        present(64'h3000);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        @(negedge clk);
        chk("sat.a", 64'(stall_cnt_a), 64'd15);
        chk("sat.b", 64'(stall_cnt_b), 64'd15);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr.a", 64'(stall_cnt_a), 64'd0);

        // asynchronous reset between edges while in the skid state
        present(64'h3004);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar.a.skid", 64'(in_ready_a), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar.a.out_valid", 64'(out_valid_a), 64'd0);
        chk("ar.a.out_pc",    out_pc_a, 64'd0);
        chk("ar.a.out_instr", 64'(out_instr_a), 64'h13);
        chk("ar.a.in_ready",  64'(in_ready_a), 64'd1);
        chk("ar.a.stall_cnt", 64'(stall_cnt_a), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = {$urandom, $urandom};
            in_instr  = $urandom;
            out_ready = (i % 100 < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            clr_cnt   = ($urandom_range(0, 63) == 0);
            step();
        end
        in_valid = 0; flush = 0; clr_cnt = 0; out_ready = 1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage_hs.md
Name: if_id_stage_hs

Overview:
- Parametrised IF/ID pipeline stage between instruction fetch and decode.
- Registers PC and instruction using a valid/ready handshake instead of a free-running latch.
- Optional 2-entry skid buffer breaks the ready path, giving full throughput with a registered in_ready.
- Flush inserts a NOP bubble (branch/jump redirect); a saturating counter records decode backpressure cycles.

Parameters:
- PC_WIDTH, 64, width of the program-counter field.
- INSTR_WIDTH, 32, width of the instruction field.
- NOP_INSTR, 32'h00000013, instruction value presented while invalid, after reset and after flush.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  fetch presents a valid PC/instruction.
- in_ready  output  1  stage accepts data this cycle.
- in_pc  input  PC_WIDTH  fetched PC.
- in_instr  input  INSTR_WIDTH  fetched instruction.
- flush  input  1  discard all held and incoming entries.
- out_valid  output  1  decode-side entry valid.
- out_ready  input  1  decode consumes this cycle.
- out_pc  output  PC_WIDTH  registered PC.
- out_instr  output  INSTR_WIDTH  registered instruction.
- stall_cnt  output  CNT_WIDTH  saturating count of backpressure cycles.
- clr_cnt  input  1  synchronous clear of stall_cnt.

Behaviour:
- Handshake rules:
  - Transfer in when in_valid && in_ready at a rising edge.
  - Transfer out when out_valid && out_ready.
  - in_valid must not depend combinationally on in_ready.
- Reset (reset=0, asynchronous):
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, skid entry invalid, stall_cnt=0.
  - in_ready=1 while reset is held and immediately after release.
- Latency: 1 cycle from accepted input to out_valid.
- States with SKID_EN=1 (2-bit occupancy):
  - EMPTY: main invalid.
    - Input accepted -> FULL.
  - FULL: main valid, skid empty.
    - Accept and consume in the same cycle: main loads new data, stay FULL.
    - Accept without consume: incoming word goes to skid -> SKID.
    - Consume without accept -> EMPTY.
  - SKID: both valid; in_ready=0.
    - Consume: skid moves to main -> FULL. No acceptance this cycle.
- Ready rules:
  - in_ready is a register output equal to "state != SKID".
  - SKID_EN=0: in_ready = !out_valid || out_ready (combinational). The stage never holds more than 1 entry.
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.
- Flush (sampled at clock edge, highest priority):
  - Next state EMPTY; out_valid=0, out_instr=NOP_INSTR, out_pc=0.
  - Skid cleared; in_valid in the same cycle is dropped.
  - in_ready=1 the next cycle.
- Hold: while out_valid && !out_ready, out_pc and out_instr are stable.
- Invalid outputs: out_instr=NOP_INSTR and out_pc=0 whenever out_valid=0.
- stall_cnt:
  - Increments by 1 each cycle out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_WIDTH-1, no wrap.
  - clr_cnt has priority over increment.
- Simultaneous flush and clr_cnt: both take effect.
- Reset mid-transfer: all held data is lost; no output glitch other than the forced reset values.

Decomposition:
- Shared package (pipeline package, e.g. pipe_pkg):
  - NOP_INSTR constant.
  - Occupancy state enum {EMPTY, FULL, SKID}.
  - if_id_payload struct {pc, instr}.
- Natural sub-module: skid_buffer.
  - Generic ready/valid 2-entry register, parameter DATA_WIDTH.
  - if_id_stage_hs instantiates it with DATA_WIDTH = PC_WIDTH+INSTR_WIDTH.
  - Top level adds flush, NOP substitution and stall counter.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1, stall_cnt=0.
- Streaming: in_valid=1 with PC 0x1000, 0x1004, 0x1008, out_ready=1 -> out_pc follows 1 cycle later, one entry per cycle, no bubbles.
- Backpressure (SKID_EN=1), steps in order:
  - out_ready=0 after 0x1000 is presented; offer 0x1004 -> in_ready drops to 0 next cycle, 0x1004 held in skid.
  - Raise out_ready -> 0x1000 then 0x1004 in order; stall_cnt equals the number of cycles out_ready was low.
- Flush: flush=1 in the SKID state with in_valid=1 (PC 0x2000) -> next cycle out_valid=0, out_instr=NOP, in_ready=1; 0x2000 never appears.
- Saturation: CNT_WIDTH=4, out_ready=0 for 20 cycles with valid data -> stall_cnt stops at 15; clr_cnt=1 -> 0.
- Async reset mid-stall: assert reset=0 between clock edges while in SKID -> outputs take reset values immediately, before the next clk edge.
